// File: rtl/core_types_pkg.sv
// Shared encodings for the write-back stage: source select, load size and FSM states.
// Also provides the load-width helper used by the align/extend logic.
package core_types_pkg;

    typedef enum logic [1:0] {
        WbResult = 2'b00,
        WbLoad   = 2'b01,
        WbPc4    = 2'b10,
        WbCsr    = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        LdByte  = 2'b00,
        LdHalf  = 2'b01,
        LdWord  = 2'b10,
        LdDword = 2'b11
    } ld_size_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StWaitMem = 2'b01,
        StDrain   = 2'b10
    } wb_state_e;

    // Dword on a 32-bit datapath degenerates to a full-width word.
    function automatic int unsigned ld_bits(ld_size_e size, int unsigned xlen);
        unique case (size)
            LdByte:  ld_bits = 8;
            LdHalf:  ld_bits = 16;
            LdWord:  ld_bits = 32;
            default: ld_bits = xlen;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it to the full data width.
module load_align
    import core_types_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned AW = $clog2(XLEN / 8),
    localparam int unsigned IW = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [AW-1:0]   addr_lo,
    output logic [XLEN-1:0] data
);

    int unsigned     nbits;
    logic [AW-1:0]   off;
    logic [AW+2:0]   shamt;
    logic [XLEN-1:0] shifted;
    logic [IW-1:0]   msb;
    logic            fill;

    always_comb begin
        nbits   = ld_bits(ld_size_e'(size), XLEN);
        // Address bits below the access size are dropped, so misaligned
        // accesses read the naturally aligned container.
        off     = addr_lo & ~AW'(nbits / 8 - 1);
        shamt   = {off, 3'b000};
        shifted = rdata >> shamt;
        msb     = IW'(nbits - 1);
        fill    = ~uns & shifted[msb];
        data    = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            data[i] = (i < int'(nbits)) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: selects the result source, waits for late load data and
// drives a registered register-file write port with a retire counter.
module write_back_unit
    import core_types_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5,
    localparam int unsigned AW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            Wreg,
    input  logic [1:0]      wb_sel,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [AW-1:0]   addr_lo,
    input  logic [RA_W-1:0] rd,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] csr_data,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            flush,
    output logic            Wreg_out,
    output logic [RA_W-1:0] rd_out,
    output logic [XLEN-1:0] Wdata,
    output logic [31:0]     retire_cnt
);

    wb_state_e       state_q;
    logic [RA_W-1:0] lat_rd_q;
    logic            lat_wreg_q;
    logic [1:0]      lat_size_q;
    logic            lat_uns_q;
    logic [AW-1:0]   lat_addr_q;

    logic            is_load;
    logic [1:0]      al_size;
    logic            al_uns;
    logic [AW-1:0]   al_addr;
    logic [XLEN-1:0] ld_data;
    logic            done;
    logic [RA_W-1:0] done_rd;
    logic            done_wreg;
    logic [XLEN-1:0] done_data;
    logic            do_write;

    assign in_ready = (state_q == StIdle);
    assign is_load  = (wb_sel_e'(wb_sel) == WbLoad);

    // Same-cycle loads use the live fields; late responses use the latched copy.
    always_comb begin
        al_size = in_ready ? ld_size     : lat_size_q;
        al_uns  = in_ready ? ld_unsigned : lat_uns_q;
        al_addr = in_ready ? addr_lo     : lat_addr_q;
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata  (mem_rdata),
        .size   (al_size),
        .uns    (al_uns),
        .addr_lo(al_addr),
        .data   (ld_data)
    );

    always_comb begin
        done      = 1'b0;
        done_rd   = rd;
        done_wreg = Wreg;
        done_data = ld_data;
        unique case (state_q)
            StIdle:    done = in_valid && !flush && (!is_load || mem_rvalid);
            StWaitMem: begin
                done      = mem_rvalid && !flush;
                done_rd   = lat_rd_q;
                done_wreg = lat_wreg_q;
            end
            default:   done = 1'b0;
        endcase
        if (in_ready) begin
            unique case (wb_sel_e'(wb_sel))
                WbResult: done_data = result;
                WbPc4:    done_data = pc_plus4;
                WbCsr:    done_data = csr_data;
                default:  done_data = ld_data;
            endcase
        end
        // x0 is hardwired, so writes to it never reach the register file.
        do_write = done && done_wreg && (done_rd != '0);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= StIdle;
            lat_rd_q   <= '0;
            lat_wreg_q <= 1'b0;
            lat_size_q <= '0;
            lat_uns_q  <= 1'b0;
            lat_addr_q <= '0;
            Wreg_out   <= 1'b0;
            rd_out     <= '0;
            Wdata      <= '0;
            retire_cnt <= '0;
        end else begin
            Wreg_out <= do_write;
            if (done) begin
                rd_out <= done_rd;
                Wdata  <= done_data;
            end
            if (do_write) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (in_valid && is_load && !mem_rvalid) begin
                        if (flush) begin
                            state_q <= StDrain;
                        end else begin
                            state_q    <= StWaitMem;
                            lat_rd_q   <= rd;
                            lat_wreg_q <= Wreg;
                            lat_size_q <= ld_size;
                            lat_uns_q  <= ld_unsigned;
                            lat_addr_q <= addr_lo;
                        end
                    end
                end
                StWaitMem: begin
                    if (mem_rvalid) begin
                        state_q <= StIdle;
                    end else if (flush) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (mem_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: a vector table of single-cycle
// completions followed by hand-written multi-cycle load, flush and reset sequences.
module tb_write_back_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;
    localparam int unsigned NVEC = 13;

    logic            clk = 1'b0;
    logic            nReset = 1'b1;
    logic            in_valid;
    logic            in_ready;
    logic            Wreg;
    logic [1:0]      wb_sel;
    logic [1:0]      ld_size;
    logic            ld_unsigned;
    logic [1:0]      addr_lo;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] csr_data;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            flush;
    logic            Wreg_out;
    logic [RA_W-1:0] rd_out;
    logic [XLEN-1:0] Wdata;
    logic [31:0]     retire_cnt;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_cnt = '0;

    typedef struct {
        logic        v;
        logic        wr;
        logic [1:0]  sel;
        logic [1:0]  sz;
        logic        uns;
        logic [1:0]  al;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] pc4;
        logic [31:0] csr;
        logic        rv;
        logic [31:0] rdata;
        logic        fl;
        logic        e_w;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
    } vec_t;

    vec_t vecs[NVEC];

    write_back_unit #(
        .XLEN(XLEN),
        .RA_W(RA_W)
    ) dut (
        .clk        (clk),
        .nReset     (nReset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Wreg       (Wreg),
        .wb_sel     (wb_sel),
        .ld_size    (ld_size),
        .ld_unsigned(ld_unsigned),
        .addr_lo    (addr_lo),
        .rd         (rd),
        .result     (result),
        .pc_plus4   (pc_plus4),
        .csr_data   (csr_data),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .Wreg_out   (Wreg_out),
        .rd_out     (rd_out),
        .Wdata      (Wdata),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_port(input string pfx, input logic e_w, input logic [4:0] e_rd,
                              input logic [31:0] e_d, input logic e_ready);
        chk({pfx, ".wreg_out"}, 64'(Wreg_out), 64'(e_w));
        chk({pfx, ".rd_out"}, 64'(rd_out), 64'(e_rd));
        chk({pfx, ".wdata"}, 64'(Wdata), 64'(e_d));
        chk({pfx, ".retire_cnt"}, 64'(retire_cnt), 64'(exp_cnt));
        chk({pfx, ".in_ready"}, 64'(in_ready), 64'(e_ready));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        Wreg        = 1'b0;
        wb_sel      = 2'b00;
        ld_size     = 2'b00;
        ld_unsigned = 1'b0;
        addr_lo     = 2'd0;
        rd          = 5'd0;
        result      = '0;
        pc_plus4    = '0;
        csr_data    = '0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        flush       = 1'b0;
    endtask

    task automatic present(input logic [1:0] sel, input logic [1:0] sz, input logic uns,
                           input logic [1:0] al, input logic [4:0] r, input logic [31:0] res,
                           input logic rv, input logic [31:0] rdat, input logic fl);
        in_valid    = 1'b1;
        Wreg        = 1'b1;
        wb_sel      = sel;
        ld_size     = sz;
        ld_unsigned = uns;
        addr_lo     = al;
        rd          = r;
        result      = res;
        mem_rvalid  = rv;
        mem_rdata   = rdat;
        flush       = fl;
    endtask

    initial begin
        //         v     wr    sel    sz     uns   al    rd      res           pc4          csr           rv    rdata         fl    e_w   e_rd    e_d
        vecs[0]  = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd3,  32'h12345678, 32'h0,       32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 5'd3,  32'h12345678};
        vecs[1]  = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd0,  32'hDEADBEEF, 32'h0,       32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 5'd0,  32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 2'd0, 5'd1,  32'h0,        32'h00000104, 32'h0,       1'b0, 32'h0,        1'b0, 1'b1, 5'd1,  32'h00000104};
        vecs[3]  = '{1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 2'd0, 5'd31, 32'h0,        32'h0,       32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 1'b1, 5'd31, 32'hCAFEF00D};
        vecs[4]  = '{1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 2'd2, 5'd5,  32'h0,        32'h0,       32'h0,        1'b1, 32'h80010000, 1'b0, 1'b1, 5'd5,  32'h00008001};
        vecs[5]  = '{1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'd1, 5'd6,  32'h0,        32'h0,       32'h0,        1'b1, 32'h12348056, 1'b0, 1'b1, 5'd6,  32'hFFFFFF80};
        vecs[6]  = '{1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'd3, 5'd7,  32'h0,        32'h0,       32'h0,        1'b1, 32'hF00D1234, 1'b0, 1'b1, 5'd7,  32'hFFFFF00D};
        vecs[7]  = '{1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 2'd3, 5'd8,  32'h0,        32'h0,       32'h0,        1'b1, 32'h89ABCDEF, 1'b0, 1'b1, 5'd8,  32'h89ABCDEF};
        vecs[8]  = '{1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 2'd0, 5'd9,  32'h0,        32'h0,       32'h0,        1'b1, 32'h000000F0, 1'b0, 1'b1, 5'd9,  32'h000000F0};
        vecs[9]  = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd10, 32'h11111111, 32'h0,       32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 5'd9,  32'h000000F0};
        vecs[10] = '{1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 2'd0, 5'd11, 32'h0,        32'h0,       32'h0,        1'b1, 32'hAAAAAAAA, 1'b1, 1'b0, 5'd9,  32'h000000F0};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 5'd12, 32'h22222222, 32'h0,       32'h0,        1'b1, 32'h33333333, 1'b0, 1'b0, 5'd9,  32'h000000F0};
        vecs[12] = '{1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'd2, 5'd13, 32'h0,        32'h0,       32'h0,        1'b1, 32'h007F0000, 1'b0, 1'b1, 5'd13, 32'h0000007F};

        idle_inputs();
        #2 nReset = 1'b0;
        #1 check_port("reset", 1'b0, 5'd0, 32'h0, 1'b1);
        step();
        nReset = 1'b1;
        step();

        for (int i = 0; i < int'(NVEC); i++) begin
            in_valid    = vecs[i].v;
            Wreg        = vecs[i].wr;
            wb_sel      = vecs[i].sel;
            ld_size     = vecs[i].sz;
            ld_unsigned = vecs[i].uns;
            addr_lo     = vecs[i].al;
            rd          = vecs[i].rd;
            result      = vecs[i].res;
            pc_plus4    = vecs[i].pc4;
            csr_data    = vecs[i].csr;
            mem_rvalid  = vecs[i].rv;
            mem_rdata   = vecs[i].rdata;
            flush       = vecs[i].fl;
            step();
            idle_inputs();
            if (vecs[i].e_w) exp_cnt = exp_cnt + 32'd1;
            check_port($sformatf("vec%0d", i), vecs[i].e_w, vecs[i].e_rd, vecs[i].e_d, 1'b1);
        end

        // Signed byte load with response two cycles late; live fields scrambled meanwhile.
        present(2'b01, 2'b00, 1'b0, 2'd3, 5'd4, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        idle_inputs();
        ld_size = 2'b10; ld_unsigned = 1'b1; addr_lo = 2'd0; Wreg = 1'b0;
        check_port("late.w1", 1'b0, 5'd13, 32'h0000007F, 1'b0);
        step();
        check_port("late.w2", 1'b0, 5'd13, 32'h0000007F, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF7F01;
        step();
        idle_inputs();
        exp_cnt = exp_cnt + 32'd1;
        check_port("late.done", 1'b1, 5'd4, 32'hFFFFFF80, 1'b1);

        // Flush while waiting, response three cycles later; flush in DRAIN is ignored.
        present(2'b01, 2'b01, 1'b0, 2'd0, 5'd5, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        idle_inputs();
        flush = 1'b1;
        step();
        check_port("drain.c1", 1'b0, 5'd4, 32'hFFFFFF80, 1'b0);
        step();
        flush = 1'b0;
        check_port("drain.c2", 1'b0, 5'd4, 32'hFFFFFF80, 1'b0);
        step();
        check_port("drain.c3", 1'b0, 5'd4, 32'hFFFFFF80, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h00001234;
        step();
        idle_inputs();
        check_port("drain.done", 1'b0, 5'd4, 32'hFFFFFF80, 1'b1);

        // Flush in WAIT_MEM coinciding with the response.
        present(2'b01, 2'b10, 1'b0, 2'd0, 5'd6, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        idle_inputs();
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        idle_inputs();
        check_port("flush_rv", 1'b0, 5'd4, 32'hFFFFFF80, 1'b1);

        // Flushed load in IDLE with no response goes through DRAIN.
        present(2'b01, 2'b10, 1'b0, 2'd0, 5'd7, 32'h0, 1'b0, 32'h0, 1'b1);
        step();
        idle_inputs();
        check_port("idle_flush.c1", 1'b0, 5'd4, 32'hFFFFFF80, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h12121212;
        step();
        idle_inputs();
        check_port("idle_flush.done", 1'b0, 5'd4, 32'hFFFFFF80, 1'b1);

        // Stray response in IDLE.
        mem_rvalid = 1'b1; mem_rdata = 32'h00000005;
        step();
        idle_inputs();
        check_port("stray_rv", 1'b0, 5'd4, 32'hFFFFFF80, 1'b1);

        // Counter wrap from a preset value near the top.
        force dut.retire_cnt = 32'hFFFF_FFFE;
        #1 release dut.retire_cnt;
        exp_cnt = 32'hFFFF_FFFE;
        present(2'b00, 2'b00, 1'b0, 2'd0, 5'd2, 32'h0000A5A5, 1'b0, 32'h0, 1'b0);
        step();
        idle_inputs();
        exp_cnt = 32'hFFFF_FFFF;
        check_port("wrap.top", 1'b1, 5'd2, 32'h0000A5A5, 1'b1);
        present(2'b00, 2'b00, 1'b0, 2'd0, 5'd3, 32'h00005A5A, 1'b0, 32'h0, 1'b0);
        step();
        idle_inputs();
        exp_cnt = 32'h0;
        check_port("wrap.zero", 1'b1, 5'd3, 32'h00005A5A, 1'b1);
        present(2'b00, 2'b00, 1'b0, 2'd0, 5'd3, 32'h00000077, 1'b0, 32'h0, 1'b0);
        step();
        idle_inputs();
        exp_cnt = 32'h1;
        check_port("wrap.one", 1'b1, 5'd3, 32'h00000077, 1'b1);

        // Asynchronous reset while a load is outstanding; the late response is dropped.
        present(2'b01, 2'b10, 1'b0, 2'd0, 5'd9, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        idle_inputs();
        check_port("rst.wait", 1'b0, 5'd3, 32'h00000077, 1'b0);
        #2 nReset = 1'b0;
        exp_cnt = 32'h0;
        #1 check_port("rst.async", 1'b0, 5'd0, 32'h0, 1'b1);
        #1 nReset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000FFFF;
        step();
        idle_inputs();
        check_port("rst.stale_rv", 1'b0, 5'd0, 32'h0, 1'b1);
        present(2'b00, 2'b00, 1'b0, 2'd0, 5'd1, 32'h00000001, 1'b0, 32'h0, 1'b0);
        step();
        idle_inputs();
        exp_cnt = 32'h1;
        check_port("rst.after", 1'b1, 5'd1, 32'h00000001, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width; legal values are 32 and 64.
REQ-002 Parameter RA_W, default 5, SHALL set the register address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 nReset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_valid  in  1  SHALL mean the MEM stage presents an instruction.
REQ-006 in_ready  out  1  SHALL mean this block accepts the instruction this cycle.
REQ-007 Wreg  in  1  SHALL be the register-write enable of the presented instruction.
REQ-008 wb_sel  in  2  SHALL select the source: 00 result, 01 load data, 10 pc_plus4, 11 csr_data.
REQ-009 ld_size  in  2  SHALL be the load size: 00 byte, 01 half, 10 word, 11 dword (XLEN=64 only).
REQ-010 ld_unsigned  in  1  SHALL select zero-extension when 1 and sign-extension when 0.
REQ-011 addr_lo  in  log2(XLEN/8)  SHALL be the low load-address bits.
REQ-012 rd  in  RA_W  SHALL be the destination register.
REQ-013 result, pc_plus4, csr_data  in  XLEN  SHALL be the candidate write-back values.
REQ-014 mem_rvalid  in  1 and mem_rdata  in  XLEN SHALL be the data-memory response.
REQ-015 flush  in  1  SHALL kill the in-flight or presented instruction.
REQ-016 Wreg_out  out  1, rd_out  out  RA_W, Wdata  out  XLEN SHALL be the registered register-file write port.
REQ-017 retire_cnt  out  32  SHALL count register writes issued.

Function
REQ-018 States: IDLE, WAIT_MEM, DRAIN.
REQ-019 in_ready SHALL be 1 in IDLE and 0 in WAIT_MEM and DRAIN.
REQ-020 In IDLE, an accepted non-load (wb_sel != 01, no flush) SHALL drive the write port on the next cycle (latency 1).
REQ-021 In IDLE, an accepted load with mem_rvalid=1 in the same cycle SHALL complete with latency 1 and no WAIT_MEM.
REQ-022 In IDLE, an accepted load with mem_rvalid=0 SHALL latch rd, Wreg, ld_size, ld_unsigned and addr_lo, and enter WAIT_MEM.
REQ-023 In WAIT_MEM, mem_rvalid=1 SHALL drive the write port on the next cycle and return to IDLE.
REQ-024 Load data SHALL be mem_rdata shifted right by addr_lo*8 (byte), addr_lo[MSB:1]*16 (half) or addr_lo[MSB:2]*32 (word), then extended to XLEN per ld_unsigned.
REQ-025 Misaligned low address bits below the access size SHALL be ignored.
REQ-026 Wreg_out SHALL be 0 whenever rd = 0, whatever the value of Wreg.
REQ-027 In any cycle with no completing instruction, Wreg_out SHALL be 0; rd_out and Wdata SHALL hold their previous values.
REQ-028 Flush in IDLE SHALL discard the presented instruction; a flushed load with mem_rvalid=0 SHALL enter DRAIN.
REQ-029 Flush in WAIT_MEM with mem_rvalid=0 SHALL enter DRAIN.
REQ-030 Flush in WAIT_MEM with mem_rvalid=1 SHALL return to IDLE with no write.
REQ-031 DRAIN SHALL consume the next mem_rvalid without writing, then go to IDLE; flush in DRAIN SHALL have no effect.
REQ-032 retire_cnt SHALL increment by 1 on each cycle in which Wreg_out=1, and SHALL wrap from 0xFFFF_FFFF to 0.

Reset
REQ-033 nReset low SHALL immediately set state=IDLE, Wreg_out=0, rd_out=0, Wdata=0, retire_cnt=0 and clear all latched load fields.
REQ-034 A reset taken in WAIT_MEM or DRAIN SHALL abandon the outstanding response; a mem_rvalid arriving after reset in IDLE with no accepted load SHALL be ignored.

Structure
REQ-035 The wb_sel and ld_size encodings and the state enum SHALL be defined in core_types_pkg.
REQ-036 The load align/extend logic SHALL be a combinational sub-module, load_align.

Verification
REQ-037 ALU op: result=0x1234_5678, rd=3, Wreg=1 -> next cycle Wreg_out=1, rd_out=3, Wdata=0x1234_5678, retire_cnt=1.
REQ-038 Load byte signed: mem_rdata=0x80FF_7F01, addr_lo=3, rvalid delayed 2 cycles -> in_ready=0 for 2 cycles, then Wdata=0xFFFF_FF80.
REQ-039 Load half unsigned: addr_lo=2, mem_rdata=0x8001_0000, rvalid in the same cycle -> next cycle Wdata=0x0000_8001, no WAIT_MEM.
REQ-040 rd=0, Wreg=1, result=0xDEAD_BEEF -> Wreg_out=0, retire_cnt unchanged.
REQ-041 Flush during WAIT_MEM, rvalid 3 cycles later -> no write, DRAIN→IDLE, in_ready=1 on the cycle after rvalid.
REQ-042 retire_cnt preset to 0xFFFF_FFFF via writes, one more write -> retire_cnt=0; nReset asserted mid-WAIT_MEM -> all outputs 0 asynchronously.
